// File: rtl/modulo_demux_scan.sv
// Registered 1:N one-hot demux with manual select or dwell-timed automatic scan.
// Optional anti-ghosting blank cycle on every channel change: define SCAN_BLANK_EN.
module modulo_demux_scan #(
  parameter int SEL_W = 3,
  parameter int DWELL = 4,
  parameter int DW_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  input_e,
  input  logic                  input_mode,
  input  logic [SEL_W-1:0]      input_sel,
  output logic [(2**SEL_W)-1:0] out,
  output logic [SEL_W-1:0]      cur_sel,
  output logic                  wrap
);

  localparam int N = 2 ** SEL_W;
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(N - 1);

  logic [N-1:0]     r_out;
  logic [SEL_W-1:0] r_cur_sel;
  logic             r_wrap;
  logic [DW_W-1:0]  r_dwell_cnt;

  logic [SEL_W-1:0] w_next_sel;
  logic [DW_W-1:0]  w_next_cnt;
  logic             w_next_wrap;
  logic             w_out_en;
  logic [N-1:0]     w_onehot;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_sel  = r_cur_sel;
    w_next_cnt  = r_dwell_cnt;
    w_next_wrap = 1'b0;
    w_out_en    = 1'b0;

    if (!input_mode) begin
      w_next_sel = input_sel;
      w_next_cnt = '0;
      w_out_en   = input_e;
    end else if (input_e) begin
      w_out_en = 1'b1;
      if (r_dwell_cnt == DWELL_LAST) begin
        // N is a power of two, so the increment wraps N-1 -> 0 by itself.
        w_next_cnt  = '0;
        w_next_sel  = r_cur_sel + 1'b1;
        w_next_wrap = (r_cur_sel == SEL_LAST);
      end else begin
        w_next_cnt = r_dwell_cnt + 1'b1;
      end
    end

`ifdef SCAN_BLANK_EN
    if (w_next_sel != r_cur_sel) begin
      w_out_en = 1'b0;
    end
`endif
  end

  // Output ordering is reversed: select k drives out[N-1-k].
  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < N; i++) begin
      w_onehot[i] = w_out_en && (SEL_W'(N - 1 - i) == w_next_sel);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_cur_sel   <= '0;
      r_wrap      <= 1'b0;
      r_dwell_cnt <= '0;
    end else begin
      r_out       <= w_onehot;
      r_cur_sel   <= w_next_sel;
      r_wrap      <= w_next_wrap;
      r_dwell_cnt <= w_next_cnt;
    end
  end

  assign out     = r_out;
  assign cur_sel = r_cur_sel;
  assign wrap    = r_wrap;

endmodule

// File: doc/modulo_demux_scan.md
Name: modulo_demux_scan

Overview:
- Registered, parametrised 1:N demultiplexer with an automatic scan mode; successor to the fixed 1:8 combinational demux.
- Drives N one-hot enable lines (row/digit select for multiplexed display) either from an external select (manual) or from an internal dwell-timed channel counter (scan).
- Keeps the existing output ordering: select value k asserts out[N-1-k].

Parameters:
- SEL_W, 3, select width; N = 2**SEL_W outputs (legal 1..6).
- DWELL, 4, clock cycles each channel stays selected in scan mode (legal >= 1).
- DW_W, 16, width of the internal dwell counter; DWELL-1 must fit.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- input_e  in  1  data/enable input routed to the selected output; in scan mode also gates advancing.
- input_mode  in  1  0 = manual, 1 = scan.
- input_sel  in  SEL_W  channel select used in manual mode.
- out  out  N  one-hot (or all-zero) registered outputs; out[N-1-cur_sel] active.
- cur_sel  out  SEL_W  currently selected channel (registered).
- wrap  out  1  one-cycle pulse when scan wraps from channel N-1 to 0.

Behaviour:
- One clock domain. Reset is synchronous and active-low, clocked by clk; port rst_n.
- Reset (rst_n=0 at rising edge): out=0, cur_sel=0, wrap=0, dwell_cnt=0, blank flag=0. Reset wins over all other inputs, including mid-scan.
- All outputs registered; out and cur_sel always updated together, so in any cycle out is either 0 or onehot at index N-1-cur_sel.
- Manual mode (input_mode=0): each cycle cur_sel <= input_sel; out <= input_e ? onehot(N-1-input_sel) : 0. Latency 1 cycle. dwell_cnt held at 0. wrap=0.
- Scan mode (input_mode=1), input_e=1: dwell_cnt increments each cycle; when dwell_cnt==DWELL-1: dwell_cnt<=0, cur_sel<=cur_sel+1 mod N. Each channel active exactly DWELL cycles. wrap=1 in the cycle cur_sel becomes 0 via wrap-around; otherwise 0.
- Scan mode, input_e=0: dwell_cnt and cur_sel frozen, out=0 next cycle, wrap=0. On input_e returning to 1, scan resumes from frozen dwell_cnt.
- DWELL=1: cur_sel advances every cycle.
- N=2 (SEL_W=1): counter toggles; wrap every second advance.
- Mode switch manual->scan: scan starts at current cur_sel with dwell_cnt=0; first channel gets full DWELL cycles.
- Mode switch scan->manual: next cycle cur_sel=input_sel, dwell_cnt cleared.
- input_sel ignored in scan mode; input_mode sampled every cycle.

Optional Feature:
- Macro SCAN_BLANK_EN.
- Defined: whenever cur_sel changes value (scan advance or manual select change), out is forced to 0 for that first cycle (cur_sel already shows the new value), then the onehot asserts from the next cycle. In scan mode, the blank cycle counts as the first of the DWELL cycles. With DWELL=1, out stays 0 throughout scanning. Purpose: anti-ghosting.
- Undefined: no blanking; out switches directly between one-hot codes.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with input_e=1, input_mode=1 -> out=8'h00, cur_sel=0, wrap=0. Release -> first edge gives out=8'h80.
- Manual: mode=0, input_e=1, input_sel=0,3,7 on successive cycles -> one cycle later out=8'h80, 8'h10, 8'h01. With input_e=0 -> out=8'h00.
- Scan DWELL=4: mode=1, input_e=1 from reset -> cur_sel steps 0..7, each held 4 cycles; out walks 8'h80->8'h01. wrap pulses exactly 1 cycle when cur_sel goes 7->0 (every 32 cycles).
- Freeze: during scan at cur_sel=2, dwell_cnt=1, drop input_e for 5 cycles -> out=0, cur_sel stays 2. Restore -> channel 2 active 2 more cycles, then cur_sel=3.
- Mode switch/reset mid-scan: scan at cur_sel=5, switch to manual with input_sel=1 -> next cycle cur_sel=1, out=8'h40. Switch back to scan -> channel 1 held 4 cycles. Assert rst_n=0 mid-dwell -> all cleared next edge.
- SCAN_BLANK_EN: scan DWELL=4 -> per channel 1 cycle out=0 then 3 cycles onehot. Manual change of input_sel 2->6 -> one zero cycle then out=8'h02.
